// File: rtl/gzip_ctrl_regs.sv
// gzip_ctrl_regs: control/status register bank and interrupt logic for NUM_CH Deflate cores.
// Optional per-channel JOB_COUNT statistics are built when GZIP_CTRL_STATS_EN is defined.
module gzip_ctrl_regs #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] DEVICE_ID  = 32'h000000B9,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ip_wen,
  input  logic                  ip_ren,
  input  logic [ADDR_WIDTH-1:0] ip_addr,
  input  logic [3:0]            ip_wstrb,
  input  logic [31:0]           ip_wdata,
  output logic                  ip_wack,
  output logic                  ip_rack,
  output logic [31:0]           ip_rdata,
  output logic                  ip_error,
  output logic [NUM_CH-1:0]     core_rst_n,
  output logic [2*NUM_CH-1:0]   core_btype,
  input  logic [96*NUM_CH-1:0]  core_debug,
  output logic                  irq
);
  localparam int unsigned BLK_W    = ADDR_WIDTH - 5;
  localparam logic [3:0]  RST_LOAD = 4'(RST_CYCLES);

  logic [BLK_W-1:0]  blk;
  logic [2:0]        off;
  logic              is_glb;
  logic              mapped;
  logic [NUM_CH-1:0] ch_hit;

  logic [NUM_CH-1:0] run_q, run_d;
  logic [1:0]        btype_q [NUM_CH];
  logic [1:0]        btype_d [NUM_CH];
  logic [3:0]        srst_cnt_q [NUM_CH];
  logic [3:0]        srst_cnt_d [NUM_CH];
  logic [NUM_CH-1:0] srst_active;
  logic [NUM_CH-1:0] done_q, done_d, done_prev_q, done_prev_d;
  logic [NUM_CH-1:0] done_rise;
  logic [NUM_CH-1:0] irq_status_q, irq_status_d, irq_enable_q, irq_enable_d, irq_clr;
  logic              irq_q, irq_d;
  logic              wack_q, wack_d, rack_q, rack_d, error_q, error_d;
  logic [31:0]       rdata_q, rdata_d;

  logic              sel_run, sel_active;
  logic [1:0]        sel_btype, bt_new;
  logic [95:0]       sel_dbg;
  logic [31:0]       sel_job;
  logic [31:0]       rd_val;
  logic              wr_err, wr_ok;
  logic              unused_bits;

  assign unused_bits = ^{ip_addr[1:0], ip_wstrb[3:1], ip_wdata, core_debug};

  // Word address splits into a 8-word block (0 = global, c+1 = channel c) and an offset.
  assign blk = ip_addr[ADDR_WIDTH-1:5];
  assign off = ip_addr[4:2];

  always_comb begin
    is_glb = (blk == '0) && !off[2];
    ch_hit = '0;
    for (int c = 0; c < NUM_CH; c++) ch_hit[c] = (blk == BLK_W'(c + 1));
  end
  assign mapped = is_glb | (|ch_hit);

  always_comb begin
    core_btype = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      srst_active[c]       = (srst_cnt_q[c] != 4'd0);
      core_rst_n[c]        = run_q[c] & ~srst_active[c];
      core_btype[2*c +: 2] = btype_q[c];
    end
  end

`ifdef GZIP_CTRL_STATS_EN
  logic [31:0] job_cnt_q [NUM_CH];
  logic [31:0] job_cnt_d [NUM_CH];

  // A clear on the same cycle as an increment leaves the counter at zero.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      job_cnt_d[c] = job_cnt_q[c];
      if (done_rise[c] && (job_cnt_q[c] != 32'hFFFF_FFFF)) job_cnt_d[c] = job_cnt_q[c] + 32'd1;
      if (ip_wen && ch_hit[c] && (off == 3'd6)) job_cnt_d[c] = '0;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) job_cnt_q[c] <= rst ? 32'd0 : job_cnt_d[c];
  end
`endif

  always_comb begin
    sel_run    = 1'b0;
    sel_active = 1'b0;
    sel_btype  = 2'd0;
    sel_dbg    = '0;
    sel_job    = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_hit[c]) begin
        sel_run    = run_q[c];
        sel_active = srst_active[c];
        sel_btype  = btype_q[c];
        sel_dbg    = core_debug[96*c +: 96];
`ifdef GZIP_CTRL_STATS_EN
        sel_job    = job_cnt_q[c];
`endif
      end
    end
  end

  always_comb begin
    rd_val = '0;
    if (is_glb) begin
      case (off[1:0])
        2'd0:    rd_val = DEVICE_ID;
        2'd1:    rd_val = 32'(NUM_CH);
        2'd2:    rd_val = 32'(irq_status_q);
        default: rd_val = 32'(irq_enable_q);
      endcase
    end else begin
      case (off)
        3'd0:    rd_val = {30'd0, sel_active, sel_run};
        3'd1:    rd_val = {30'd0, sel_btype};
        3'd2:    rd_val = {29'd0, sel_dbg[2:0]};
        3'd3:    rd_val = sel_dbg[39:8];
        3'd4:    rd_val = sel_dbg[71:40];
        3'd5:    rd_val = {8'd0, sel_dbg[95:72]};
        3'd6:    rd_val = sel_job;
        default: rd_val = '0;
      endcase
    end
  end

  // BTYPE guard checks the value the register would hold after strobe merging.
  assign bt_new = ip_wstrb[0] ? ip_wdata[1:0] : sel_btype;

  always_comb begin
    wr_err = 1'b0;
    if (!mapped) begin
      wr_err = 1'b1;
    end else if (is_glb) begin
      wr_err = !off[1];
    end else begin
      case (off)
        3'd1:                      wr_err = sel_run | (bt_new == 2'b11);
        3'd2, 3'd3, 3'd4, 3'd5:    wr_err = 1'b1;
        default:                   wr_err = 1'b0;
      endcase
    end
  end
  assign wr_ok = ip_wen & ~wr_err;

  always_comb begin
    irq_clr      = '0;
    irq_enable_d = irq_enable_q;
    if (wr_ok && is_glb && ip_wstrb[0]) begin
      if (off[1:0] == 2'd2) irq_clr      = ip_wdata[NUM_CH-1:0];
      if (off[1:0] == 2'd3) irq_enable_d = ip_wdata[NUM_CH-1:0];
    end

    run_d       = run_q;
    done_d      = '0;
    done_prev_d = done_q;
    done_rise   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      btype_d[c]    = btype_q[c];
      srst_cnt_d[c] = srst_active[c] ? (srst_cnt_q[c] - 4'd1) : 4'd0;
      done_d[c]     = core_debug[96*c];
      done_rise[c]  = done_q[c] & ~done_prev_q[c] & core_rst_n[c];
      if (wr_ok && ch_hit[c] && ip_wstrb[0]) begin
        if (off == 3'd0) begin
          run_d[c] = ip_wdata[0];
          if (ip_wdata[1]) srst_cnt_d[c] = RST_LOAD;
        end
        if (off == 3'd1) btype_d[c] = ip_wdata[1:0];
      end
    end

    // Set wins over a simultaneous W1C of the same bit.
    irq_status_d = (irq_status_q & ~irq_clr) | done_rise;
    irq_d        = |(irq_status_q & irq_enable_q);

    wack_d  = ip_wen;
    rack_d  = ip_ren;
    rdata_d = (ip_ren && mapped) ? rd_val : 32'd0;
    error_d = (ip_ren & ~mapped) | (ip_wen & wr_err);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q        <= '0;
      done_q       <= '0;
      done_prev_q  <= '0;
      irq_status_q <= '0;
      irq_enable_q <= '0;
      irq_q        <= 1'b0;
      wack_q       <= 1'b0;
      rack_q       <= 1'b0;
      error_q      <= 1'b0;
      rdata_q      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        btype_q[c]    <= 2'd0;
        srst_cnt_q[c] <= 4'd0;
      end
    end else begin
      run_q        <= run_d;
      done_q       <= done_d;
      done_prev_q  <= done_prev_d;
      irq_status_q <= irq_status_d;
      irq_enable_q <= irq_enable_d;
      irq_q        <= irq_d;
      wack_q       <= wack_d;
      rack_q       <= rack_d;
      error_q      <= error_d;
      rdata_q      <= rdata_d;
      for (int c = 0; c < NUM_CH; c++) begin
        btype_q[c]    <= btype_d[c];
        srst_cnt_q[c] <= srst_cnt_d[c];
      end
    end
  end

  assign ip_wack  = wack_q;
  assign ip_rack  = rack_q;
  assign ip_rdata = rdata_q;
  assign ip_error = error_q;
  assign irq      = irq_q;

endmodule
